// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory responder with four-phase ready handshake.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN: reject odd byte addresses and flag addr_error.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_select,
    input  logic                  mem_read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  addr_error
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_read;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] ram [2**(ADDR_WIDTH-1)];
    logic [ADDR_WIDTH-2:0] word_idx;
    logic                  misaligned;
    logic                  access;

    assign word_idx   = req_addr[ADDR_WIDTH-1:1];
    assign misaligned = ALIGN_CHECK & req_addr[0];
    assign access     = (state == WAIT) && (cnt == 4'd0);

    // RAM store port; contents survive reset but a reset edge cancels the write
    always_ff @(posedge clk) begin
        if (reset && access && !req_read && !misaligned)
            ram[word_idx] <= req_wdata;
    end

    // Request FSM: latch in IDLE, count wait states, access, hold ready until select drops
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_addr   <= '0;
            req_read   <= 1'b0;
            req_wdata  <= '0;
            rdata      <= '0;
            ready      <= 1'b0;
            addr_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_select) begin
                        req_addr  <= addr;
                        req_read  <= mem_read;
                        req_wdata <= wdata;
                        cnt       <= 4'(WAIT_STATES);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (req_read && !misaligned)
                            rdata <= ram[word_idx];
                        ready      <= 1'b1;
                        addr_error <= misaligned;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (!mem_select) begin
                        ready      <= 1'b0;
                        addr_error <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    ready      <= 1'b0;
                    addr_error <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench for data_mem_responder with WAIT_STATES=2 and WAIT_STATES=0 instances.
module tb_data_mem_responder;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam logic [15:0] EXP_W5  = 16'hBEEF;
    localparam logic        EXP_ERR = 1'b1;
`else
    localparam logic [15:0] EXP_W5  = 16'h5555;
    localparam logic        EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_select;
    logic        mem_read;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata2, rdata0;
    logic        ready2, ready0, err2, err0;
    logic        fast;
    logic        rdy, err;
    logic [15:0] rd;
    int          nvec = 0;
    int          nerr = 0;
    int          lat;
    int          hi;

    assign rdy = fast ? ready0 : ready2;
    assign err = fast ? err0 : err2;
    assign rd  = fast ? rdata0 : rdata2;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .mem_select(mem_select), .mem_read(mem_read),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2), .addr_error(err2)
    );

    data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_select(mem_select), .mem_read(mem_read),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .addr_error(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic r, input logic [7:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        mem_select = 1'b1;
        mem_read   = r;
        addr       = a;
        wdata      = d;
    endtask

    task automatic wait_ready(output int l);
        for (l = 0; l < 40; l++) begin
            @(negedge clk);
            if (rdy) break;
        end
    endtask

    task automatic release_sel(input string tag);
        @(posedge clk);
        #1;
        mem_select = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(tag, {31'd0, rdy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fast       = 1'b0;
        reset      = 1'b0;
        mem_select = 1'b0;
        mem_read   = 1'b0;
        addr       = 8'h00;
        wdata      = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata2", {16'd0, rdata2}, 32'd0);
        check("rst_ready2", {31'd0, ready2}, 32'd0);
        check("rst_err2", {31'd0, err2}, 32'd0);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        req(1'b0, 8'h0A, 16'hBEEF);
        wait_ready(lat);
        check("st_lat", lat, 4);
        check("st_err", {31'd0, err}, 32'd0);
        release_sel("st_rel");

        req(1'b0, 8'h0A, 16'hDEAD);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_select = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, rdy}, 32'd0);
        check("abort_rdata", {16'd0, rd}, 32'd0);

        req(1'b1, 8'h0A, 16'h0000);
        wait_ready(lat);
        check("ld_lat", lat, 4);
        check("ld_rdata", {16'd0, rd}, 32'h0000BEEF);
        release_sel("ld_rel");

        req(1'b0, 8'h10, 16'h1234);
        wait_ready(lat);
        check("hold_lat", lat, 4);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy) hi++;
        end
        check("hold_ready", hi, 10);
        release_sel("hold_rel");
        req(1'b1, 8'h10, 16'h0000);
        wait_ready(lat);
        check("hold_ld", {16'd0, rd}, 32'h00001234);
        release_sel("hold_ld_rel");

        req(1'b1, 8'h0A, 16'h0000);
        @(posedge clk);
        #1 mem_select = 1'b0;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy) hi++;
        end
        check("drop_pulse", hi, 1);
        check("drop_rdata", {16'd0, rd}, 32'h0000BEEF);

        req(1'b0, 8'h0B, 16'h5555);
        wait_ready(lat);
        check("mis_lat", lat, 4);
        check("mis_err", {31'd0, err}, {31'd0, EXP_ERR});
        release_sel("mis_rel");
        check("mis_err_clr", {31'd0, err}, 32'd0);
        req(1'b1, 8'h0A, 16'h0000);
        wait_ready(lat);
        check("mis_w5", {16'd0, rd}, {16'd0, EXP_W5});
        release_sel("mis_w5_rel");
        req(1'b1, 8'h0B, 16'h0000);
        wait_ready(lat);
        check("mis_ld", {16'd0, rd}, {16'd0, EXP_W5});
        check("mis_ld_err", {31'd0, err}, {31'd0, EXP_ERR});
        release_sel("mis_ld_rel");

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        fast = 1'b1;
        req(1'b0, 8'h00, 16'h1111);
        wait_ready(lat);
        check("f_st0_lat", lat, 2);
        release_sel("f_st0_rel");
        req(1'b0, 8'hFE, 16'h2222);
        wait_ready(lat);
        check("f_st1_lat", lat, 2);
        release_sel("f_st1_rel");
        req(1'b1, 8'h00, 16'h0000);
        wait_ready(lat);
        check("f_ld0_lat", lat, 2);
        check("f_ld0", {16'd0, rd}, 32'h00001111);
        release_sel("f_ld0_rel");
        req(1'b1, 8'hFE, 16'h0000);
        wait_ready(lat);
        check("f_ld1_lat", lat, 2);
        check("f_ld1", {16'd0, rd}, 32'h00002222);
        release_sel("f_ld1_rel");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
